counter_burst_sched: RTL
========================

Name: counter_burst_sched

Overview:
- Scheduler that shares one 4-bit enable-gated counter (ports clk, rst, enable, count) between NREQ requesters.
- Arbitrates requests and clears the counter before each grant.
- Drives the counter's enable for exactly the requested number of cycles, then reports completion.
- Sits between requester logic and the shared counter instance; owns the counter's rst and enable pins.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDXW, 3, width of owner index; must satisfy 2**IDXW >= NREQ.

Ports:
- clk  input  1  system clock, single domain.
- rst  input  1  synchronous, active-high reset, sampled on rising clk.
- req  input  NREQ  per-requester request level; held until done or abort.
- req_len  input  4*NREQ  burst length per requester; slice [4i+3:4i] belongs to requester i; 0 encodes 16.
- grant  output  NREQ  one-hot grant to the current owner.
- owner  output  IDXW  binary index of current owner; 0 when idle.
- cnt_rst  output  1  drives shared counter rst; one-cycle pulse.
- cnt_enable  output  1  drives shared counter enable.
- done  output  1  one-cycle pulse at burst end.
- aborted  output  1  valid with done; 1 if burst ended early because owner dropped req.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- All outputs are decoded from registered state or registers; no combinational path from req to any output.
- Reset (rst=1 at a clk edge):
  - state=IDLE, grant=0, owner=0, cnt_rst=1, cnt_enable=0, done=0, aborted=0, busy=0.
  - RR pointer=0.
  - cnt_rst is forced high while rst is high, so the counter is also cleared.
- FSM states: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - If any req bit is 1 at edge T, choose a winner.
  - Latch the winner's req_len into remaining; 0 loads 16, 5-bit register.
  - Go to CLEAR at T+1. Otherwise stay in IDLE.
- CLEAR (one cycle):
  - grant[w]=1, owner=w, cnt_rst=1, cnt_enable=0, busy=1.
  - Go to RUN.
- RUN:
  - grant held, cnt_enable=1.
  - remaining decrements each cycle.
  - When remaining==1 at an edge, go to DONE with aborted=0.
  - The counter therefore sees exactly L enabled cycles and ends at L mod 16 (L=16 wraps to 0).
- Abort:
  - If req[owner]=0 at an edge while in RUN, go to DONE with aborted=1.
  - The counter keeps every increment up to and including that cycle.
  - Abort takes precedence over normal completion in the same cycle; aborted=1.
- DONE (one cycle):
  - done=1, grant still asserted, cnt_enable=0.
  - Go to IDLE; grant drops at the next cycle.
- Timing for an idle-to-done burst of length L:
  - req seen at T; CLEAR at T+1; RUN at T+2..T+1+L; DONE at T+2+L; IDLE at T+3+L.
  - At least one IDLE cycle occurs between bursts.
- Request changes:
  - req changes of non-owners during a burst are ignored.
  - req_len changes after the latch are ignored.
- Synchronous rst in any state aborts immediately to the reset values above. No done pulse is produced.

Optional Feature:
- Macro: COUNTER_SCHED_RR_EN.
- Defined (round-robin):
  - Search starts at index (last_owner+1) mod NREQ.
  - The pointer updates when entering CLEAR.
  - Reset pointer makes requester 0 the first candidate.
- Undefined (fixed priority):
  - The lowest-index active req always wins.
  - The pointer logic is absent.

Test Plan:
- Reset check: rst=1 for 2 cycles -> grant=0, cnt_enable=0, busy=0, cnt_rst=1; release rst -> cnt_rst=0 next cycle, count=0.
- Single burst: req=4'b0010, len slice1=5 -> grant=0010 and cnt_rst at T+1; cnt_enable high for exactly 5 cycles; done=1, aborted=0 at T+7; count=5.
- Length 0: req0 with len=0 -> 16 enable cycles; count wraps to 0; done at T+18.
- Contention (RR defined): req=4'b0101 held, len=2 each -> grants in order 0001, 0100, 0001. Same stimulus with RR undefined -> 0001 repeatedly.
- Abort: owner 1 with len=10 drops req after 3 RUN cycles -> done=1, aborted=1 the next cycle; count=3; grant=0 one cycle later.
- Mid-burst reset: rst=1 in RUN with count=4 -> next cycle state IDLE, grant=0, no done pulse, count=0.

Source files
------------

// File: rtl/counter_burst_sched.sv
// counter_burst_sched: shares one enable-gated counter among NREQ requesters; COUNTER_SCHED_RR_EN selects round-robin, otherwise fixed priority
module counter_burst_sched #(
  parameter int NREQ = 4,
  parameter int IDXW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] req_len,
  output logic [NREQ-1:0]   grant,
  output logic [IDXW-1:0]   owner,
  output logic              cnt_rst,
  output logic              cnt_enable,
  output logic              done,
  output logic              aborted,
  output logic              busy
);
  localparam int NX = 2**IDXW;
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [NX-1:0] req_x;
  logic [4*NX-1:0] len_x;
  logic [IDXW-1:0] own_r, win;
  logic [3:0] wlen;
  logic [4:0] rem;
  logic ab_r, rst_q;
  assign req_x = NX'(req);
  assign len_x = (4*NX)'(req_len);
  assign wlen = len_x[{win, 2'b00} +: 4];
`ifdef COUNTER_SCHED_RR_EN
  logic [IDXW-1:0] ptr, cand;
  always_comb begin
    win = '0;
    cand = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      cand = IDXW'((int'(ptr) + i) % NREQ);
      if (req_x[cand]) win = cand;
    end
  end
  always_ff @(posedge clk) ptr <= rst ? '0 : (state == IDLE && |req) ? IDXW'((int'(win) + 1) % NREQ) : ptr;
`else
  always_comb begin
    win = '0;
    for (int i = NREQ-1; i >= 0; i--) if (req_x[IDXW'(i)]) win = IDXW'(i);
  end
`endif
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = (state == IDLE)  ? (|req ? CLEAR : IDLE) :
               (state == CLEAR) ? RUN :
               (state == RUN)   ? ((!req_x[own_r] || rem == 5'd1) ? DONE : RUN) :
                                  IDLE;
  end
  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      own_r <= '0;
      rem <= '0;
      ab_r <= 1'b0;
    end else if (state == IDLE) begin
      own_r <= win;
      rem <= {wlen == 4'd0, wlen};
      ab_r <= 1'b0;
    end else if (state == RUN) begin
      rem <= rem - 5'd1;
      ab_r <= !req_x[own_r];
    end
  end
  assign busy = state != IDLE;
  assign grant = busy ? (NREQ'(1) << own_r) : '0;
  assign owner = busy ? own_r : '0;
  assign cnt_rst = rst | rst_q | (state == CLEAR);
  assign cnt_enable = state == RUN;
  assign done = state == DONE;
  assign aborted = done & ab_r;
endmodule
